wb_slave_mem: RTL and testbench

Wishbone B3 classic-cycle slave responder backed by a word-addressed register-file memory with byte enables and a configurable number of wait states. It is the target-side counterpart to the Wishbone master interface in the quickstart environment. It sits on the slave side of the interconnect and answers every qualified `cyc`/`stb` request with exactly one `ack`, or with `err` when error responses are compiled in.

---
 rtl/wb_slave_mem.sv | 162 ++++++++++++++++
 tb/tb_wb_slave_mem.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone B3 classic-cycle slave backed by a byte-enabled word memory with fixed wait states.
// Define WB_SLAVE_MEM_ERR_EN to terminate out-of-range word indices with wb_err_o instead of wrapping.
module wb_slave_mem #(
    parameter int unsigned DW          = 32,
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_cyc_i,
    input  logic            wb_stb_i,
    input  logic            wb_we_i,
    input  logic [31:0]     wb_adr_i,
    input  logic [DW/8-1:0] wb_sel_i,
    input  logic [DW-1:0]   wb_dat_i,
    output logic [DW-1:0]   wb_dat_o,
    output logic            wb_ack_o,
    output logic            wb_err_o
);

    localparam int unsigned NB  = DW / 8;
    localparam int unsigned OFF = (NB > 1) ? $clog2(NB) : 0;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q;
    logic [AW-1:0]   adr_q;
    logic            we_q;
    logic [NB-1:0]   sel_q;
    logic [DW-1:0]   dat_q;
    logic            oor_q;

    logic            req;
    logic            in_oor;
    logic            enter_resp;
    logic [AW-1:0]   acc_idx;
    logic            acc_we;
    logic            acc_oor;
    logic [NB-1:0]   acc_sel;
    logic [DW-1:0]   acc_dat;
    logic            unused_adr;

    logic [DW-1:0]   mem [DEPTH];

    assign req        = wb_cyc_i & wb_stb_i;
    assign unused_adr = ^wb_adr_i;

`ifdef WB_SLAVE_MEM_ERR_EN
    assign in_oor = |(wb_adr_i >> (OFF + AW));
`else
    assign in_oor = 1'b0;
`endif

    // With zero wait states RESP is entered straight from IDLE, so the
    // access must use the live bus inputs rather than the captured copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_idx = wb_adr_i[OFF +: AW];
            acc_we  = wb_we_i;
            acc_oor = in_oor;
            acc_sel = wb_sel_i;
            acc_dat = wb_dat_i;
        end else begin
            acc_idx = adr_q;
            acc_we  = we_q;
            acc_oor = oor_q;
            acc_sel = sel_q;
            acc_dat = dat_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign enter_resp = (state_d == ST_RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            dat_q   <= '0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && req) begin
                adr_q <= wb_adr_i[OFF +: AW];
                we_q  <= wb_we_i;
                sel_q <= wb_sel_i;
                dat_q <= wb_dat_i;
                oor_q <= in_oor;
                cnt_q <= WAIT_LOAD;
            end else if (state_q == ST_WAIT && cnt_q != '0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Termination is registered out of RESP, so the pulse lands in the
    // cycle after RESP and coincides with the next IDLE capture window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= (state_q == ST_RESP) && !oor_q;
            if (enter_resp && !acc_we && !acc_oor) begin
                wb_dat_o <= mem[acc_idx];
            end
        end
    end

`ifdef WB_SLAVE_MEM_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ST_RESP) && oor_q;
        end
    end

    assign wb_err_o = err_q;
`else
    assign wb_err_o = 1'b0;
`endif

    // Memory has no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && enter_resp && acc_we && !acc_oor) begin
            for (int unsigned b = 0; b < NB; b++) begin
                if (acc_sel[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mem.sv
// tb_wb_slave_mem: randomized scoreboard bench for wb_slave_mem against a word-array reference model.
module tb_wb_slave_mem;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned WAITC = 1;

    typedef struct {
        bit          is_err;
        bit          is_read;
        logic [31:0] data;
        logic [31:0] mask;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] adr_i = '0;
    logic [3:0]  sel_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic        err_o;

    int          cycle = 0;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] ref_mem   [DEPTH];
    logic [3:0]  ref_known [DEPTH];
    exp_t        sbq[$];
    exp_t        mon_e;

    wb_slave_mem #(.DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_cyc_i (cyc_i),
        .wb_stb_i (stb_i),
        .wb_we_i  (we_i),
        .wb_adr_i (adr_i),
        .wb_sel_i (sel_i),
        .wb_dat_i (dat_i),
        .wb_dat_o (dat_o),
        .wb_ack_o (ack_o),
        .wb_err_o (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic bit is_oor(input logic [31:0] a);
`ifdef WB_SLAVE_MEM_ERR_EN
        return (a >> 2) >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] bytemask(input logic [3:0] k);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (k[b]) m[8*b +: 8] = 8'hFF;
        return m;
    endfunction

    // Drives one request; returns #1 after the expected response edge with cyc/stb still up.
    task automatic xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat, input bit drop_stb, input bit push);
        exp_t e;
        int   w = widx(adr);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        e.cyc     = cycle + 2 + int'(WAITC);
        e.is_err  = is_oor(adr);
        e.is_read = !we;
        e.data    = ref_mem[w];
        e.mask    = bytemask(ref_known[w]);
        if (push) begin
            if (we && !e.is_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel[b]) begin
                        ref_mem[w][8*b +: 8] = dat[8*b +: 8];
                        ref_known[w][b] = 1'b1;
                    end
                end
            end
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        if (drop_stb) stb_i = 1'b0;
        repeat (WAITC + 1) @(posedge clk);
        #1;
    endtask

    task automatic abort_xfer(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                              input logic [31:0] dat);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        @(posedge clk); #1;
        cyc_i = 1'b0; stb_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        cyc_i = 1'b0; stb_i = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (sbq.size() > 0 && sbq[0].cyc < cycle) begin
                tests++; fails++;
                $display("FAIL missing_resp: got no ack/err expected one at cycle %0d (now %0d)", sbq[0].cyc, cycle);
                void'(sbq.pop_front());
            end
            if (ack_o || err_o) begin
                check("ack_err_excl", {31'b0, ack_o & err_o}, 32'd0);
                if (sbq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_resp: got ack=%b err=%b expected none (cycle %0d)", ack_o, err_o, cycle);
                end else begin
                    mon_e = sbq.pop_front();
                    check("resp_cycle", 32'(cycle), 32'(mon_e.cyc));
                    check("resp_kind", {30'b0, ack_o, err_o}, mon_e.is_err ? 32'd1 : 32'd2);
                    if (mon_e.is_read && !mon_e.is_err)
                        check("rdata", dat_o & mon_e.mask, mon_e.data & mon_e.mask);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ref_mem[i] = '0;
            ref_known[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, ack_o}, 32'd0);
        check("rst_err", {31'b0, err_o}, 32'd0);
        check("rst_dat", dat_o, 32'd0);
        rst_n = 1'b1;

        xfer(1, 32'h0000_0000, 4'hF, 32'h0BAD_C0DE, 0, 1); idle(1);
        xfer(1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 0, 1); idle(1);
        xfer(0, 32'h0000_0010, 4'hF, 32'h0, 0, 1);         idle(1);
        xfer(1, 32'h0000_0010, 4'h2, 32'h0000_AB00, 0, 1); idle(1);
        xfer(0, 32'h0000_0013, 4'hF, 32'h0, 0, 1);         idle(1);

        xfer(1, 32'h0000_0100, 4'hF, 32'h1234_5678, 0, 1); idle(1);
        xfer(0, 32'h0000_0000, 4'hF, 32'h0, 0, 1);
        xfer(0, 32'h0000_0100, 4'hF, 32'h0, 0, 1);         idle(1);

        xfer(1, 32'h0000_0020, 4'hF, 32'h55AA_55AA, 0, 1); idle(1);
        abort_xfer(1, 32'h0000_0020, 4'hF, 32'hCAFE_F00D); idle(3);
        xfer(0, 32'h0000_0020, 4'hF, 32'h0, 0, 1);         idle(1);
        xfer(1, 32'h0000_0024, 4'h5, 32'hA1B2_C3D4, 1, 1);
        xfer(0, 32'h0000_0024, 4'hF, 32'h0, 0, 1);         idle(1);

        // back-to-back writes, then a third one killed by reset in its wait cycle
        xfer(1, 32'h0000_0004, 4'hF, 32'h1111_1111, 0, 1);
        xfer(1, 32'h0000_0008, 4'hF, 32'h2222_2222, 0, 1);
        xfer(0, 32'h0000_0010, 4'hF, 32'h0, 0, 1);
        cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 32'h8; sel_i = 4'hF; dat_i = 32'h3333_3333;
        @(posedge clk); #1;
        rst_n = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        #1;
        check("rst_wait_ack", {31'b0, ack_o}, 32'd0);
        check("rst_wait_dat", dat_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        xfer(0, 32'h0000_0008, 4'hF, 32'h0, 0, 1);
        xfer(0, 32'h0000_0004, 4'hF, 32'h0, 0, 1);         idle(1);

        // reset asserted while ack is high clears it asynchronously
        xfer(0, 32'h0000_0010, 4'hF, 32'h0, 0, 0);
        check("pre_rst_ack", {31'b0, ack_o}, 32'd1);
        check("pre_rst_dat", dat_o, ref_mem[widx(32'h10)]);
        rst_n = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
        #1;
        check("async_rst_ack", {31'b0, ack_o}, 32'd0);
        check("async_rst_dat", dat_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            logic [31:0] a;
            int          kind;
            a = {24'd0, 4'($urandom_range(0, 15)), 4'($urandom)};
            if ($urandom_range(0, 3) == 0) a[31:8] = 24'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0)
                abort_xfer(1'($urandom), a, 4'($urandom), $urandom);
            else
                xfer(1'($urandom), a, 4'($urandom), $urandom, kind == 1, 1);
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 2));
        end

        idle(5);
        check("sb_drain", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
